// File: rtl/cpu6502_pkg.sv
// Shared types and constants for the cpu6502_lite core:
// sequencer states, opcode classes, register selects and opcodes.
package cpu6502_pkg;

    typedef enum logic [3:0] {
        VEC_LO,
        VEC_HI,
        FETCH,
        IMM,
        EXEC,
        ABS_LO,
        ABS_HI,
        READ,
        WRITE
    } state_t;

    typedef enum logic [2:0] {
        CL_NOP,
        CL_IMM,
        CL_INC,
        CL_XFER,
        CL_STORE,
        CL_LDABS,
        CL_JMP
    } op_class_t;

    typedef enum logic [1:0] {
        REG_A,
        REG_X,
        REG_Y
    } reg_sel_t;

    typedef struct packed {
        op_class_t cls;
        reg_sel_t  tgt;
        logic      illegal;
    } dec_t;

    localparam logic [7:0] OP_LDA_IMM = 8'hA9;
    localparam logic [7:0] OP_LDX_IMM = 8'hA2;
    localparam logic [7:0] OP_LDY_IMM = 8'hA0;
    localparam logic [7:0] OP_NOP     = 8'hEA;
    localparam logic [7:0] OP_INX     = 8'hE8;
    localparam logic [7:0] OP_INY     = 8'hC8;
    localparam logic [7:0] OP_TAX     = 8'hAA;
    localparam logic [7:0] OP_TXA     = 8'h8A;
    localparam logic [7:0] OP_STA_ABS = 8'h8D;
    localparam logic [7:0] OP_STX_ABS = 8'h8E;
    localparam logic [7:0] OP_STY_ABS = 8'h8C;
    localparam logic [7:0] OP_LDA_ABS = 8'hAD;
    localparam logic [7:0] OP_JMP_ABS = 8'h4C;

    localparam logic [15:0] VECTOR_DEFAULT = 16'hFFFC;

endpackage

// File: rtl/cpu6502_decode.sv
// Opcode decoder: maps an opcode byte to its execution class,
// the register it targets, and whether it is unsupported.
module cpu6502_decode
    import cpu6502_pkg::*;
(
    input  logic [7:0] opcode_i,
    output dec_t       dec_o
);

    // Pure lookup; anything unknown becomes an illegal 2-cycle NOP.
    always_comb begin
        dec_o = '{cls: CL_NOP, tgt: REG_A, illegal: 1'b0};
        case (opcode_i)
            OP_LDA_IMM: dec_o = '{cls: CL_IMM,   tgt: REG_A, illegal: 1'b0};
            OP_LDX_IMM: dec_o = '{cls: CL_IMM,   tgt: REG_X, illegal: 1'b0};
            OP_LDY_IMM: dec_o = '{cls: CL_IMM,   tgt: REG_Y, illegal: 1'b0};
            OP_NOP:     dec_o = '{cls: CL_NOP,   tgt: REG_A, illegal: 1'b0};
            OP_INX:     dec_o = '{cls: CL_INC,   tgt: REG_X, illegal: 1'b0};
            OP_INY:     dec_o = '{cls: CL_INC,   tgt: REG_Y, illegal: 1'b0};
            OP_TAX:     dec_o = '{cls: CL_XFER,  tgt: REG_X, illegal: 1'b0};
            OP_TXA:     dec_o = '{cls: CL_XFER,  tgt: REG_A, illegal: 1'b0};
            OP_STA_ABS: dec_o = '{cls: CL_STORE, tgt: REG_A, illegal: 1'b0};
            OP_STX_ABS: dec_o = '{cls: CL_STORE, tgt: REG_X, illegal: 1'b0};
            OP_STY_ABS: dec_o = '{cls: CL_STORE, tgt: REG_Y, illegal: 1'b0};
            OP_LDA_ABS: dec_o = '{cls: CL_LDABS, tgt: REG_A, illegal: 1'b0};
            OP_JMP_ABS: dec_o = '{cls: CL_JMP,   tgt: REG_A, illegal: 1'b0};
            default:    dec_o = '{cls: CL_NOP,   tgt: REG_A, illegal: 1'b1};
        endcase
    end

endmodule

// File: rtl/cpu6502_lite.sv
// Minimal 6502-style core: reset vector fetch, immediate/absolute
// loads, absolute stores, JMP, INX/INY/TAX/TXA, with rdy stalls.
module cpu6502_lite
    import cpu6502_pkg::*;
#(
    parameter int          BOOT_MODE   = 0,
    parameter logic [15:0] VECTOR_ADDR = VECTOR_DEFAULT,
    parameter logic [15:0] RESET_PC    = 16'h0200
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  di,
    input  logic        rdy,
    output logic [15:0] ab,
    output logic [7:0]  dout,
    output logic        we,
    output logic        sync,
    output logic        illegal,
    output logic [7:0]  a_out,
    output logic [7:0]  x_out,
    output logic [7:0]  y_out,
    output logic        flag_z,
    output logic        flag_n
);

    localparam state_t      RST_STATE = (BOOT_MODE == 1) ? FETCH : VEC_LO;
    localparam logic [15:0] RST_PC    = (BOOT_MODE == 1) ? RESET_PC : 16'h0000;

    state_t      state_q, state_d;
    op_class_t   cls_q, cls_d;
    reg_sel_t    tgt_q, tgt_d;
    logic [15:0] pc_q, pc_d;
    logic [7:0]  lo_q, lo_d, hi_q, hi_d;
    logic [7:0]  a_q, a_d, x_q, x_d, y_q, y_d;
    logic        z_q, z_d, n_q, n_d, ill_q, ill_d;
    logic [7:0]  src, res;
    logic        ld;
    dec_t        dec;

    cpu6502_decode u_decode (
        .opcode_i (di),
        .dec_o    (dec)
    );

    // Register named by the latched target select.
    always_comb begin
        src = a_q;
        case (tgt_q)
            REG_X:   src = x_q;
            REG_Y:   src = y_q;
            default: ;
        endcase
    end

    // Sequencer next state; WRITE always advances, others wait on rdy.
    always_comb begin
        state_d = state_q;
        cls_d   = cls_q;
        tgt_d   = tgt_q;
        pc_d    = pc_q;
        lo_d    = lo_q;
        hi_d    = hi_q;
        a_d     = a_q;
        x_d     = x_q;
        y_d     = y_q;
        z_d     = z_q;
        n_d     = n_q;
        ill_d   = ill_q;
        res     = di;
        ld      = 1'b0;
        if (rdy || state_q == WRITE) begin
            ill_d = 1'b0;
            case (state_q)
                VEC_LO: begin
                    lo_d    = di;
                    state_d = VEC_HI;
                end
                VEC_HI: begin
                    pc_d    = {di, lo_q};
                    state_d = FETCH;
                end
                FETCH: begin
                    pc_d  = pc_q + 16'd1;
                    cls_d = dec.cls;
                    tgt_d = dec.tgt;
                    ill_d = dec.illegal;
                    case (dec.cls)
                        CL_IMM:   state_d = IMM;
                        CL_STORE,
                        CL_LDABS,
                        CL_JMP:   state_d = ABS_LO;
                        default:  state_d = EXEC;
                    endcase
                end
                IMM: begin
                    pc_d    = pc_q + 16'd1;
                    ld      = 1'b1;
                    state_d = FETCH;
                end
                EXEC: begin
                    case (cls_q)
                        CL_INC: begin
                            ld  = 1'b1;
                            res = src + 8'd1;
                        end
                        CL_XFER: begin
                            ld  = 1'b1;
                            res = (tgt_q == REG_A) ? x_q : a_q;
                        end
                        default: ;
                    endcase
                    state_d = FETCH;
                end
                ABS_LO: begin
                    lo_d    = di;
                    pc_d    = pc_q + 16'd1;
                    state_d = ABS_HI;
                end
                ABS_HI: begin
                    hi_d = di;
                    if (cls_q == CL_JMP) begin
                        pc_d    = {di, lo_q};
                        state_d = FETCH;
                    end else begin
                        pc_d    = pc_q + 16'd1;
                        state_d = (cls_q == CL_STORE) ? WRITE : READ;
                    end
                end
                READ: begin
                    ld      = 1'b1;
                    state_d = FETCH;
                end
                WRITE:   state_d = FETCH;
                default: state_d = FETCH;
            endcase
            if (ld) begin
                case (tgt_q)
                    REG_X:   x_d = res;
                    REG_Y:   y_d = res;
                    default: a_d = res;
                endcase
                z_d = (res == 8'h00);
                n_d = res[7];
            end
        end
    end

    // State registers; reset aborts any cycle in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= RST_STATE;
            cls_q   <= CL_NOP;
            tgt_q   <= REG_A;
            pc_q    <= RST_PC;
            lo_q    <= 8'h00;
            hi_q    <= 8'h00;
            a_q     <= 8'h00;
            x_q     <= 8'h00;
            y_q     <= 8'h00;
            z_q     <= 1'b0;
            n_q     <= 1'b0;
            ill_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cls_q   <= cls_d;
            tgt_q   <= tgt_d;
            pc_q    <= pc_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            a_q     <= a_d;
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
            n_q     <= n_d;
            ill_q   <= ill_d;
        end
    end

    // Address bus follows the current state directly.
    always_comb begin
        ab = pc_q;
        case (state_q)
            VEC_LO:      ab = VECTOR_ADDR;
            VEC_HI:      ab = VECTOR_ADDR + 16'd1;
            READ, WRITE: ab = {hi_q, lo_q};
            default:     ;
        endcase
    end

    assign we      = (state_q == WRITE);
    assign dout    = we ? src : 8'h00;
    assign sync    = (state_q == FETCH);
    assign illegal = ill_q;
    assign a_out   = a_q;
    assign x_out   = x_q;
    assign y_out   = y_q;
    assign flag_z  = z_q;
    assign flag_n  = n_q;

endmodule

// File: tb/tb_cpu6502_lite.sv
// Bench for cpu6502_lite: an instruction-level model expands each
// instruction into its expected bus cycles, compared every cycle.
module tb_cpu6502_lite;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rdy = 1'b1;
    logic [7:0]  di;
    logic [15:0] ab;
    logic [7:0]  dout;
    logic        we, sync, illegal;
    logic [7:0]  a_out, x_out, y_out;
    logic        flag_z, flag_n;

    logic [7:0] mem  [0:65535];
    logic [7:0] mmem [0:65535];

    typedef struct {
        logic [15:0] ab;
        logic        we;
        logic [7:0]  d;
        logic        sy;
        logic        il;
        logic [7:0]  a, x, y;
        logic        z, n;
    } cyc_t;

    cyc_t q[$];

    int checks = 0;
    int failures = 0;
    int phase_fail = 0;

    logic [15:0] mpc;
    logic [7:0]  ma, mx, my;
    logic        mz, mn;

    always #5 clk = ~clk;

    assign di = mem[ab];

    cpu6502_lite dut (
        .clk     (clk),
        .reset   (reset),
        .di      (di),
        .rdy     (rdy),
        .ab      (ab),
        .dout    (dout),
        .we      (we),
        .sync    (sync),
        .illegal (illegal),
        .a_out   (a_out),
        .x_out   (x_out),
        .y_out   (y_out),
        .flag_z  (flag_z),
        .flag_n  (flag_n)
    );

    task automatic chk(string nm, logic [31:0] act, logic [31:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            phase_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, want, $time);
        end
    endtask

    task automatic push(logic [15:0] a, logic w, logic [7:0] d, logic s, logic il);
        q.push_back('{a, w, d, s, il, ma, mx, my, mz, mn});
    endtask

    function automatic void setf(logic [7:0] v);
        mz = (v == 8'h00);
        mn = v[7];
    endfunction

    task automatic model_boot();
        ma = 8'h00; mx = 8'h00; my = 8'h00; mz = 1'b0; mn = 1'b0;
        q.delete();
        push(16'hFFFC, 1'b0, 8'h00, 1'b0, 1'b0);
        push(16'hFFFD, 1'b0, 8'h00, 1'b0, 1'b0);
        mpc = {mmem[16'hFFFD], mmem[16'hFFFC]};
    endtask

    // One whole instruction: every bus cycle sees the register state
    // from before the instruction; results appear at the next opcode.
    task automatic model_step();
        logic [7:0]  op, lo, hi, v;
        logic [15:0] ea;
        op = mmem[mpc];
        push(mpc, 1'b0, 8'h00, 1'b1, 1'b0);
        mpc = mpc + 16'd1;
        case (op)
            8'hA9, 8'hA2, 8'hA0: begin
                v = mmem[mpc];
                push(mpc, 1'b0, 8'h00, 1'b0, 1'b0);
                mpc = mpc + 16'd1;
                if (op == 8'hA9) ma = v;
                else if (op == 8'hA2) mx = v;
                else my = v;
                setf(v);
            end
            8'hEA: push(mpc, 1'b0, 8'h00, 1'b0, 1'b0);
            8'hE8: begin push(mpc, 1'b0, 8'h00, 1'b0, 1'b0); mx = mx + 8'd1; setf(mx); end
            8'hC8: begin push(mpc, 1'b0, 8'h00, 1'b0, 1'b0); my = my + 8'd1; setf(my); end
            8'hAA: begin push(mpc, 1'b0, 8'h00, 1'b0, 1'b0); mx = ma; setf(mx); end
            8'h8A: begin push(mpc, 1'b0, 8'h00, 1'b0, 1'b0); ma = mx; setf(ma); end
            8'h8D, 8'h8E, 8'h8C, 8'hAD, 8'h4C: begin
                lo = mmem[mpc];
                push(mpc, 1'b0, 8'h00, 1'b0, 1'b0);
                mpc = mpc + 16'd1;
                hi = mmem[mpc];
                push(mpc, 1'b0, 8'h00, 1'b0, 1'b0);
                mpc = mpc + 16'd1;
                ea = {hi, lo};
                if (op == 8'h4C) begin
                    mpc = ea;
                end else if (op == 8'hAD) begin
                    push(ea, 1'b0, 8'h00, 1'b0, 1'b0);
                    ma = mmem[ea];
                    setf(ma);
                end else begin
                    v = (op == 8'h8D) ? ma : (op == 8'h8E) ? mx : my;
                    push(ea, 1'b1, v, 1'b0, 1'b0);
                    mmem[ea] = v;
                end
            end
            default: push(mpc, 1'b0, 8'h00, 1'b0, 1'b1);
        endcase
    endtask

    task automatic do_reset();
        reset = 1'b1;
        rdy = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rst_ab", ab, 16'hFFFC);
        chk("rst_we", we, 0);
        chk("rst_do", dout, 0);
        chk("rst_sync", sync, 0);
        chk("rst_illegal", illegal, 0);
        chk("rst_regs", {a_out, x_out, y_out}, 0);
        chk("rst_flags", {flag_z, flag_n}, 0);
        reset = 1'b0;
    endtask

    // Compare DUT against the expected cycle queue, one entry per
    // completed cycle; stalled cycles re-check the same entry.
    task automatic run(bit directed, int limit);
        int idx = 0;
        int cyc = 0;
        int stall = 0;
        cyc_t e;
        phase_fail = 0;
        while (q.size() > 0) begin
            e = q[0];
            chk("ab", ab, e.ab);
            chk("we", we, e.we);
            chk("do", dout, e.d);
            chk("sync", sync, e.sy);
            chk("illegal", illegal, e.il);
            chk("a", a_out, e.a);
            chk("x", x_out, e.x);
            chk("y", y_out, e.y);
            chk("z", flag_z, e.z);
            chk("n", flag_n, e.n);
            if (directed) begin
                rdy = !(idx == 9 || (idx == 16 && stall < 3));
                if (idx == 16 && !rdy) stall++;
            end else begin
                rdy = ($urandom_range(0, 3) != 0);
            end
            if (e.we || rdy) begin
                if (we) mem[ab] = dout;
                void'(q.pop_front());
                idx++;
            end
            @(negedge clk);
            cyc++;
            if (cyc > limit) begin
                checks++;
                failures++;
                $display("FAIL cycle_budget: got %0d cycles, required at most %0d", cyc, limit);
                break;
            end
            if (phase_fail > 10) break;
        end
        rdy = 1'b1;
    endtask

    task automatic load_directed();
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        mem[16'hFFFC] = 8'h00; mem[16'hFFFD] = 8'h02;
        mem[16'h0200] = 8'hA9; mem[16'h0201] = 8'h80;
        mem[16'h0202] = 8'hA9; mem[16'h0203] = 8'h55;
        mem[16'h0204] = 8'h8D; mem[16'h0205] = 8'h34; mem[16'h0206] = 8'h12;
        mem[16'h0207] = 8'hA2; mem[16'h0208] = 8'hFF;
        mem[16'h0209] = 8'hE8;
        mem[16'h020A] = 8'hAD; mem[16'h020B] = 8'h00; mem[16'h020C] = 8'h40;
        mem[16'h020D] = 8'h4C; mem[16'h020E] = 8'h00; mem[16'h020F] = 8'h03;
        mem[16'h0300] = 8'h4C; mem[16'h0301] = 8'hFF; mem[16'h0302] = 8'hFF;
        mem[16'hFFFF] = 8'h02;
        mem[16'h0000] = 8'hEA;
        mem[16'h4000] = 8'hC3;
        for (int i = 0; i < 65536; i++) mmem[i] = mem[i];
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] ops [13];
        ops = '{8'hA9, 8'hA2, 8'hA0, 8'hEA, 8'hE8, 8'hC8, 8'hAA,
                8'h8A, 8'h8D, 8'h8E, 8'h8C, 8'hAD, 8'h4C};

        // Directed program, with the model pinned by hand values.
        load_directed();
        model_boot();
        for (int i = 0; i < 10; i++) model_step();
        chk("pin_len", q.size(), 28);
        chk("pin_first_fetch", {q[2].ab, 7'd0, q[2].sy}, {16'h0200, 8'h01});
        chk("pin_lda80", {q[4].a, 7'd0, q[4].n, 7'd0, q[4].z}, {8'h80, 8'h01, 8'h00});
        chk("pin_lda80_next", q[4].ab, 16'h0202);
        chk("pin_sta", {q[9].ab, 7'd0, q[9].we, q[9].d}, {16'h1234, 8'h01, 8'h55});
        chk("pin_sta_once", q[10].we, 0);
        chk("pin_inx_wrap", {q[14].x, 7'd0, q[14].z}, {8'h00, 8'h01});
        chk("pin_ldabs", {q[17].ab, q[18].a}, {16'h4000, 8'hC3});
        chk("pin_jmp", q[21].ab, 16'h0300);
        chk("pin_ill", {q[24].ab, 7'd0, q[25].il}, {16'hFFFF, 8'h01});
        chk("pin_wrap", {q[26].ab, 7'd0, q[26].sy}, {16'h0000, 8'h01});
        do_reset();
        run(1'b1, 200);

        // Reset landing on a WRITE cycle must drop the strobe at once.
        load_directed();
        do_reset();
        for (int i = 0; i < 50 && !we; i++) @(negedge clk);
        chk("wr_reached", we, 1);
        reset = 1'b1;
        #1;
        chk("rst_in_write_we", we, 0);
        chk("rst_in_write_do", dout, 0);
        chk("rst_in_write_ab", ab, 16'hFFFC);
        @(negedge clk);

        // Randomized memory images, mostly legal opcodes, random rdy.
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 65536; i++) begin
                if ($urandom_range(0, 9) < 7)
                    mem[i] = ops[$urandom_range(0, 12)];
                else
                    mem[i] = 8'($urandom);
            end
            for (int i = 0; i < 65536; i++) mmem[i] = mem[i];
            model_boot();
            for (int i = 0; i < 300; i++) model_step();
            do_reset();
            run(1'b0, 6000);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
